// File: rtl/play_sequencer.sv
// Playback sequencer: walks the note record store in order and holds each note on the
// tone-generator outputs for a tick-measured duration, with a one-tick silent gap after it.
module play_sequencer #(
    parameter int REC_CNT_BITS   = 6,
    parameter int OCTAVE_BITS    = 2,
    parameter int NOTE_BITS      = 3,
    parameter int LENGTH_BITS    = 3,
    parameter int FULL_NOTE_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      loop,
    input  logic [REC_CNT_BITS-1:0]   last_idx,
    input  logic                      tick,
    output logic [REC_CNT_BITS-1:0]   rec_cnt,
    output logic                      rec_rw,
    output logic                      rec_en,
    input  logic [OCTAVE_BITS-1:0]    octave_r,
    input  logic [NOTE_BITS-1:0]      note_r,
    input  logic [LENGTH_BITS-1:0]    length_r,
    input  logic [FULL_NOTE_BITS-1:0] full_note_r,
    output logic [OCTAVE_BITS-1:0]    play_octave,
    output logic [NOTE_BITS-1:0]      play_note,
    output logic                      play_valid,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [FULL_NOTE_BITS-1:0] REM_ONE = FULL_NOTE_BITS'(1);

    state_t                    state_q, state_d;
    logic [REC_CNT_BITS-1:0]   rec_cnt_q, rec_cnt_d;
    logic [REC_CNT_BITS-1:0]   last_q, last_d;
    logic [OCTAVE_BITS-1:0]    oct_q, oct_d;
    logic [NOTE_BITS-1:0]      note_q, note_d;
    logic [FULL_NOTE_BITS-1:0] rem_q, rem_d;
    logic [FULL_NOTE_BITS-1:0] dur_shift, dur;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      tick_en;

    // Very short lengths can shift the whole-note duration down to zero; keep at least one tick.
    assign dur_shift = full_note_r >> length_r;
    assign dur       = (dur_shift == '0) ? REM_ONE : dur_shift;
    assign tick_en   = tick && !pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rec_cnt_q <= '0;
            last_q    <= '0;
            oct_q     <= '0;
            note_q    <= '0;
            rem_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            last_q    <= last_d;
            oct_q     <= oct_d;
            note_q    <= note_d;
            rem_q     <= rem_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        last_d    = last_q;
        oct_d     = oct_q;
        note_d    = note_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        if (stop) begin
            state_d   = S_IDLE;
            rec_cnt_d = '0;
            oct_d     = '0;
            note_d    = '0;
            rem_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_FETCH;
                        rec_cnt_d = '0;
                        last_d    = last_idx;
                    end
                end
                // Store read path is combinational, so the fields are valid this cycle.
                S_FETCH: begin
                    oct_d   = octave_r;
                    note_d  = note_r;
                    rem_d   = dur;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (tick_en) begin
                        if (rem_q <= REM_ONE) begin
                            rem_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            rem_d = rem_q - REM_ONE;
                        end
                    end
                end
                S_GAP: begin
                    if (tick_en) begin
                        if (rec_cnt_q != last_q) begin
                            rec_cnt_d = rec_cnt_q + REC_CNT_BITS'(1);
                            state_d   = S_FETCH;
                        end else if (loop) begin
                            rec_cnt_d = '0;
                            state_d   = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        valid_d = (state_d == S_PLAY) && (note_d != '0) && !pause;
    end

    assign rec_cnt     = rec_cnt_q;
    assign rec_rw      = 1'b0;
    assign rec_en      = 1'b0;
    assign play_octave = oct_q;
    assign play_note   = note_q;
    assign play_valid  = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer: expected note/done records are queued at stimulus time
// and a monitor compares them as the sequencer finishes each note or ends playback.
module tb_play_sequencer;

    localparam int W = 22;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0, tick = 1'b0;
    logic [5:0] last_idx = '0;
    logic [5:0] rec_cnt;
    logic       rec_rw, rec_en;
    logic [1:0] octave_r;
    logic [2:0] note_r;
    logic [2:0] length_r;
    logic [9:0] full_note_r;
    logic [1:0] play_octave;
    logic [2:0] play_note;
    logic       play_valid, busy, done;
    logic [1:0] state_dbg;

    logic [1:0] mem_oct  [64];
    logic [2:0] mem_note [64];
    logic [2:0] mem_len  [64];
    logic [9:0] mem_full [64];

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    assign octave_r    = mem_oct[rec_cnt];
    assign note_r      = mem_note[rec_cnt];
    assign length_r    = mem_len[rec_cnt];
    assign full_note_r = mem_full[rec_cnt];

    play_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .last_idx(last_idx), .tick(tick), .rec_cnt(rec_cnt), .rec_rw(rec_rw), .rec_en(rec_en),
        .octave_r(octave_r), .note_r(note_r), .length_r(length_r), .full_note_r(full_note_r),
        .play_octave(play_octave), .play_note(play_note), .play_valid(play_valid),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic k, input logic [5:0] r, input logic [1:0] o,
                                        input logic [2:0] n, input logic [4:0] t, input logic [4:0] v);
        return {k, r, o, n, t, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic set_entry(input int idx, input logic [1:0] o, input logic [2:0] n,
                             input logic [2:0] l, input logic [9:0] f);
        mem_oct[idx]  = o;
        mem_note[idx] = n;
        mem_len[idx]  = l;
        mem_full[idx] = f;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) send_tick();
    endtask

    task automatic run_to_idle(input string name, input int max_ticks);
        int n;
        n = 0;
        while (busy && n < max_ticks) begin
            send_tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    logic [1:0]   prev_state = S_IDLE;
    logic [4:0]   tick_cnt = '0, vcnt = '0;
    logic [5:0]   cur_rec = '0;
    logic [1:0]   cur_oct = '0;
    logic [2:0]   cur_note = '0;
    logic [W-1:0] act_rec, exp_rec;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_state = S_IDLE;
            tick_cnt   = '0;
            vcnt       = '0;
        end else begin
            if (state_dbg == S_FETCH) begin
                tick_cnt = '0;
                vcnt     = '0;
            end
            if (state_dbg == S_PLAY) begin
                cur_rec  = rec_cnt;
                cur_oct  = play_octave;
                cur_note = play_note;
                if (tick && !pause) begin
                    tick_cnt = tick_cnt + 5'd1;
                    if (play_valid) vcnt = vcnt + 5'd1;
                end
            end
            if (prev_state == S_PLAY && state_dbg == S_GAP) begin
                act_rec = mk(1'b0, cur_rec, cur_oct, cur_note, tick_cnt, vcnt);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL note_unexpected: got %0h expected none", act_rec);
                end else begin
                    exp_rec = exp_q.pop_front();
                    if (act_rec !== exp_rec) begin
                        errors++;
                        $display("FAIL note_record: got %0h expected %0h", act_rec, exp_rec);
                    end
                end
            end
            if (done) begin
                act_rec = mk(1'b1, rec_cnt, 2'd0, 3'd0, 5'd0, 5'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got %0h expected none", act_rec);
                end else begin
                    exp_rec = exp_q.pop_front();
                    if (act_rec !== exp_rec) begin
                        errors++;
                        $display("FAIL done_record: got %0h expected %0h", act_rec, exp_rec);
                    end
                end
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
            prev_state = state_dbg;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, S_IDLE});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_valid"}, {31'd0, play_valid}, 32'd0);
        check({tag, "_rec_cnt"}, {26'd0, rec_cnt}, 32'd0);
        check({tag, "_octave"}, {30'd0, play_octave}, 32'd0);
        check({tag, "_note"}, {29'd0, play_note}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_entry(i, 2'd0, 3'd0, 3'd0, 10'd0);
        wait_cycles(3);
        #2 rst_n = 1'b1;
        wait_cycles(1);
        check_idle_outputs("reset");
        check("rec_rw", {31'd0, rec_rw}, 32'd0);
        check("rec_en", {31'd0, rec_en}, 32'd0);

        // single entry: 16 >> 2 = 4 ticks
        set_entry(0, 2'd2, 3'd5, 3'd2, 10'd16);
        last_idx = 6'd0;
        exp_q.push_back(mk(1'b0, 6'd0, 2'd2, 3'd5, 5'd4, 5'd4));
        exp_q.push_back(mk(1'b1, 6'd0, 2'd0, 3'd0, 5'd0, 5'd0));
        pulse_start();
        check("start_fetch", {30'd0, state_dbg}, {30'd0, S_FETCH});
        run_to_idle("single_idle", 20);
        check("single_q_empty", exp_q.size(), 32'd0);

        // three entries: 8, 4, 1 ticks
        set_entry(0, 2'd1, 3'd1, 3'd0, 10'd8);
        set_entry(1, 2'd2, 3'd2, 3'd1, 10'd8);
        set_entry(2, 2'd3, 3'd3, 3'd3, 10'd8);
        last_idx = 6'd2;
        exp_q.push_back(mk(1'b0, 6'd0, 2'd1, 3'd1, 5'd8, 5'd8));
        exp_q.push_back(mk(1'b0, 6'd1, 2'd2, 3'd2, 5'd4, 5'd4));
        exp_q.push_back(mk(1'b0, 6'd2, 2'd3, 3'd3, 5'd1, 5'd1));
        exp_q.push_back(mk(1'b1, 6'd2, 2'd0, 3'd0, 5'd0, 5'd0));
        pulse_start();
        run_to_idle("three_idle", 40);
        check("three_q_empty", exp_q.size(), 32'd0);

        // rest between two audible notes: durations 2, 3, 2
        set_entry(0, 2'd0, 3'd3, 3'd1, 10'd4);
        set_entry(1, 2'd1, 3'd0, 3'd2, 10'd12);
        set_entry(2, 2'd2, 3'd4, 3'd1, 10'd4);
        last_idx = 6'd2;
        exp_q.push_back(mk(1'b0, 6'd0, 2'd0, 3'd3, 5'd2, 5'd2));
        exp_q.push_back(mk(1'b0, 6'd1, 2'd1, 3'd0, 5'd3, 5'd0));
        exp_q.push_back(mk(1'b0, 6'd2, 2'd2, 3'd4, 5'd2, 5'd2));
        exp_q.push_back(mk(1'b1, 6'd2, 2'd0, 3'd0, 5'd0, 5'd0));
        pulse_start();
        run_to_idle("rest_idle", 40);
        check("rest_q_empty", exp_q.size(), 32'd0);

        // pause for 5 ticks after 2 ticks of a 6-tick note
        set_entry(0, 2'd1, 3'd6, 3'd3, 10'd48);
        last_idx = 6'd0;
        exp_q.push_back(mk(1'b0, 6'd0, 2'd1, 3'd6, 5'd6, 5'd6));
        exp_q.push_back(mk(1'b1, 6'd0, 2'd0, 3'd0, 5'd0, 5'd0));
        pulse_start();
        send_ticks(2);
        pause = 1'b1;
        wait_cycles(2);
        check("pause_valid_low", {31'd0, play_valid}, 32'd0);
        send_ticks(5);
        check("pause_valid_still_low", {31'd0, play_valid}, 32'd0);
        check("pause_state_held", {30'd0, state_dbg}, {30'd0, S_PLAY});
        pause = 1'b0;
        run_to_idle("pause_idle", 20);
        check("pause_q_empty", exp_q.size(), 32'd0);

        // length 7 with full note 8 clamps to one tick
        set_entry(0, 2'd3, 3'd7, 3'd7, 10'd8);
        last_idx = 6'd0;
        exp_q.push_back(mk(1'b0, 6'd0, 2'd3, 3'd7, 5'd1, 5'd1));
        exp_q.push_back(mk(1'b1, 6'd0, 2'd0, 3'd0, 5'd0, 5'd0));
        pulse_start();
        run_to_idle("len7_idle", 10);
        check("len7_q_empty", exp_q.size(), 32'd0);

        // loop over two entries twice, then stop
        set_entry(0, 2'd1, 3'd1, 3'd1, 10'd4);
        set_entry(1, 2'd2, 3'd2, 3'd1, 10'd4);
        last_idx = 6'd1;
        loop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(1'b0, 6'd0, 2'd1, 3'd1, 5'd2, 5'd2));
            exp_q.push_back(mk(1'b0, 6'd1, 2'd2, 3'd2, 5'd2, 5'd2));
        end
        pulse_start();
        send_ticks(12);
        check("loop_wrapped_rec", {26'd0, rec_cnt}, 32'd0);
        check("loop_wrapped_state", {30'd0, state_dbg}, {30'd0, S_PLAY});
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check_idle_outputs("stop");
        loop = 1'b0;
        wait_cycles(2);
        check("loop_q_empty", exp_q.size(), 32'd0);

        // stop and start together from IDLE
        last_idx = 6'd0;
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        check("stopstart_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        wait_cycles(1);
        check("stopstart_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of a note
        set_entry(0, 2'd2, 3'd5, 3'd2, 10'd16);
        pulse_start();
        send_ticks(1);
        check("pre_reset_valid", {31'd0, play_valid}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        wait_cycles(2);
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
